// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler: light codes, phase states, directions.
package intersection_phase_scheduler_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b11;

  localparam logic NS = 1'b0;
  localparam logic EW = 1'b1;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } phase_t;

  function automatic phase_t green_of(logic dir);
    return (dir == NS) ? NS_GREEN : EW_GREEN;
  endfunction

  function automatic phase_t yellow_of(logic dir);
    return (dir == NS) ? NS_YELLOW : EW_YELLOW;
  endfunction

  // Light code shown to approach dir while the controller sits in phase p.
  function automatic logic [1:0] light_of(phase_t p, logic dir);
    if (p == green_of(dir)) return GREEN;
    if (p == yellow_of(dir)) return YELLOW;
    return RED;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Request inputs and light/status outputs of the intersection phase scheduler.
interface intersection_phase_scheduler_if;
  logic       tick;
  logic [1:0] veh_req;
  logic       ped_req;
  logic [1:0] emg_req;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       ped_walk;
  logic [2:0] phase;
  logic       preempt_active;

  modport master (
    output tick, veh_req, ped_req, emg_req,
    input  ns_light, ew_light, ped_walk, phase, preempt_active
  );

  modport slave (
    input  tick, veh_req, ped_req, emg_req,
    output ns_light, ew_light, ped_walk, phase, preempt_active
  );
endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Shared phase timer: counts ticks, clears on phase change, freezes while held.
module phase_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] duration,
  output logic [CNT_W-1:0] count,
  output logic             done_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clear)         count <= '0;
    else if (tick && !hold) count <= count + CNT_W'(1);
  end

  assign done_c = tick && !hold && (count == duration - CNT_W'(1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated 4-way phase controller: detector requests, ped button, emergency preemption.
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 40,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned PED_T     = 8,
  parameter int unsigned CNT_W     = 6
) (
  input logic clk,
  input logic rst,
  intersection_phase_scheduler_if.slave bus
);

  phase_t           state, state_nxt;
  logic             next_dir, next_dir_nxt;
  logic             ped_pending, ped_pending_nxt;
  logic             preempt_nxt;
  logic             hold, clear, done_c;
  logic             emg_ns, emg_ew;
  logic [CNT_W-1:0] count, duration;
  logic [1:0]       ns_light, ew_light;
  logic             ped_walk, preempt_active;

  // NS wins when both approaches request preemption.
  assign emg_ns = bus.emg_req[0];
  assign emg_ew = bus.emg_req[1] & ~bus.emg_req[0];

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (bus.tick),
    .clear    (clear),
    .hold     (hold),
    .duration (duration),
    .count    (count),
    .done_c   (done_c)
  );

  always_comb begin
    state_nxt    = state;
    next_dir_nxt = next_dir;
    hold         = 1'b0;
    duration     = CNT_W'(ALLRED_T);
    unique case (state)
      ALL_RED: begin
        duration = CNT_W'(ALLRED_T);
        if (done_c) begin
          if (emg_ns)           state_nxt = NS_GREEN;
          else if (emg_ew)      state_nxt = EW_GREEN;
          else if (ped_pending) state_nxt = PED_WALK;
          else if (bus.veh_req[next_dir] || !bus.veh_req[~next_dir])
                                state_nxt = green_of(next_dir);
          else                  state_nxt = green_of(~next_dir);
        end
      end
      NS_GREEN: begin
        duration = CNT_W'(MAX_GREEN);
        hold     = emg_ns;
        if (emg_ew) state_nxt = NS_YELLOW;
        else if (!emg_ns && bus.tick &&
                 (done_c || (count >= CNT_W'(MIN_GREEN - 1) && (bus.veh_req[1] || ped_pending))))
          state_nxt = NS_YELLOW;
      end
      EW_GREEN: begin
        duration = CNT_W'(MAX_GREEN);
        hold     = emg_ew;
        if (emg_ns) state_nxt = EW_YELLOW;
        else if (!emg_ew && bus.tick &&
                 (done_c || (count >= CNT_W'(MIN_GREEN - 1) && (bus.veh_req[0] || ped_pending))))
          state_nxt = EW_YELLOW;
      end
      NS_YELLOW: begin
        duration = CNT_W'(YELLOW_T);
        if (done_c) begin
          state_nxt    = ALL_RED;
          next_dir_nxt = EW;
        end
      end
      EW_YELLOW: begin
        duration = CNT_W'(YELLOW_T);
        if (done_c) begin
          state_nxt    = ALL_RED;
          next_dir_nxt = NS;
        end
      end
      PED_WALK: begin
        duration = CNT_W'(PED_T);
        if (|bus.emg_req || done_c) state_nxt = ALL_RED;
      end
      default: state_nxt = ALL_RED;
    endcase

    clear = (state_nxt != state);
    // Entering the walk consumes the request; a press on that same cycle is dropped.
    ped_pending_nxt = (state_nxt == PED_WALK && state != PED_WALK) ? 1'b0
                                                                    : (ped_pending | bus.ped_req);
    preempt_nxt = (state_nxt == NS_GREEN && emg_ns) || (state_nxt == EW_GREEN && emg_ew);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ALL_RED;
      next_dir       <= NS;
      ped_pending    <= 1'b0;
      ns_light       <= RED;
      ew_light       <= RED;
      ped_walk       <= 1'b0;
      preempt_active <= 1'b0;
    end else begin
      state          <= state_nxt;
      next_dir       <= next_dir_nxt;
      ped_pending    <= ped_pending_nxt;
      ns_light       <= light_of(state_nxt, NS);
      ew_light       <= light_of(state_nxt, EW);
      ped_walk       <= (state_nxt == PED_WALK);
      preempt_active <= preempt_nxt;
    end
  end

  assign bus.ns_light       = ns_light;
  assign bus.ew_light       = ew_light;
  assign bus.ped_walk       = ped_walk;
  assign bus.phase          = state;
  assign bus.preempt_active = preempt_active;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed and randomized checks of the phase scheduler against a timing-rule model.
module tb_intersection_phase_scheduler;
  import intersection_phase_scheduler_pkg::*;

  localparam int MIN_G = 10;
  localparam int MAX_G = 40;
  localparam int YEL   = 4;
  localparam int CLR   = 2;
  localparam int WALK  = 8;

  // Model phase kinds; direction kept separately (0=NS, 1=EW).
  localparam int K_CLEAR  = 0;
  localparam int K_GREEN  = 1;
  localparam int K_YELLOW = 2;
  localparam int K_WALK   = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_kind, m_dir, m_el, m_next;
  bit m_ped, m_pre;

  intersection_phase_scheduler_if bus();

  intersection_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_kind = K_CLEAR; m_dir = 0; m_el = 0; m_next = 0; m_ped = 1'b0; m_pre = 1'b0;
  endtask

  // Advance the model by one clock using the rule set: elapsed ticks per phase.
  task automatic m_step(input bit t, input bit [1:0] veh, input bit p, input bit [1:0] emg);
    int win, nk, nd;
    win = emg[0] ? 0 : (emg[1] ? 1 : -1);
    nk  = m_kind;
    nd  = m_dir;
    case (m_kind)
      K_CLEAR: if (t && m_el + 1 == CLR) begin
        if (win >= 0)  begin nk = K_GREEN; nd = win; end
        else if (m_ped) nk = K_WALK;
        else begin
          nk = K_GREEN;
          nd = (veh[m_next] || !veh[1 - m_next]) ? m_next : 1 - m_next;
        end
      end
      K_GREEN: begin
        if (win == 1 - m_dir) nk = K_YELLOW;
        else if (win != m_dir && t &&
                 (m_el + 1 == MAX_G || (m_el + 1 >= MIN_G && (veh[1 - m_dir] || m_ped))))
          nk = K_YELLOW;
      end
      K_YELLOW: if (t && m_el + 1 == YEL) begin
        nk = K_CLEAR;
        m_next = 1 - m_dir;
      end
      default: if (emg != 2'b00 || (t && m_el + 1 == WALK)) nk = K_CLEAR;
    endcase
    if (nk != m_kind) m_el = 0;
    else if (t && !(m_kind == K_GREEN && win == m_dir)) m_el = m_el + 1;
    if (nk == K_WALK && m_kind != K_WALK) m_ped = 1'b0;
    else if (p) m_ped = 1'b1;
    m_pre  = (nk == K_GREEN && win == nd);
    m_kind = nk;
    m_dir  = nd;
  endtask

  function automatic logic [1:0] exp_light(int dir);
    if (m_kind == K_GREEN && m_dir == dir)  return 2'b11;
    if (m_kind == K_YELLOW && m_dir == dir) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_phase();
    case (m_kind)
      K_CLEAR:  return 3'(ALL_RED);
      K_GREEN:  return (m_dir == 0) ? 3'(NS_GREEN) : 3'(EW_GREEN);
      K_YELLOW: return (m_dir == 0) ? 3'(NS_YELLOW) : 3'(EW_YELLOW);
      default:  return 3'(PED_WALK);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_all();
    chk("ns_light", 8'(bus.ns_light), 8'(exp_light(0)));
    chk("ew_light", 8'(bus.ew_light), 8'(exp_light(1)));
    chk("ped_walk", 8'(bus.ped_walk), 8'(m_kind == K_WALK));
    chk("phase", 8'(bus.phase), 8'(exp_phase()));
    chk("preempt", 8'(bus.preempt_active), 8'(m_pre));
    chk("safety_lights", 8'(bus.ns_light != 2'b00 && bus.ew_light != 2'b00), 8'd0);
    chk("safety_walk", 8'(bus.ped_walk && (bus.ns_light | bus.ew_light) != 2'b00), 8'd0);
  endtask

  task automatic step();
    m_step(bus.tick, bus.veh_req, bus.ped_req, bus.emg_req);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse_ped();
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
  endtask

  task automatic run_until(input string tag, input int kind, input int dir, input int el, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (m_kind == kind && (dir < 0 || m_dir == dir) && (el < 0 || m_el == el)) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) hit = (m_kind == kind && (dir < 0 || m_dir == dir) && (el < 0 || m_el == el));
    chk(tag, 8'(hit), 8'd1);
  endtask

  task automatic count_cycles(input int n, input int which, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if ((which == 0 && bus.ns_light == 2'b11) || (which == 1 && bus.ped_walk)) cnt++;
      step();
    end
  endtask

  initial begin
    int n;
    bit [1:0] emg_hold;
    rst = 1'b1;
    bus.tick = 1'b1; bus.veh_req = 2'b00; bus.ped_req = 1'b0; bus.emg_req = 2'b00;
    m_reset();
    #2;
    check_all();
    chk("reset_phase", 8'(bus.phase), 8'(ALL_RED));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: free-running alternation, 2 clearance ticks then NS max-out
    step(); step();
    chk("t1_ns_green", 8'(bus.ns_light), 8'b11);
    count_cycles(60, 0, n);
    chk("t1_ns_green_len", 8'(n), 8'(MAX_G));
    chk("t1_ew_green", 8'(bus.ew_light), 8'b11);

    // 2: EW demand cuts NS green at min green
    run_until("t2_reach_ns", K_GREEN, 0, 0, 100);
    bus.veh_req = 2'b10;
    count_cycles(20, 0, n);
    chk("t2_ns_green_len", 8'(n), 8'(MIN_G));
    run_until("t2_reach_ew", K_GREEN, 1, -1, 10);

    // 3: ped press mid EW green
    bus.veh_req = 2'b00;
    run_until("t3_reach_ew2", K_GREEN, 1, 2, 200);
    pulse_ped();
    count_cycles(40, 1, n);
    chk("t3_walk_len", 8'(n), 8'(WALK));
    run_until("t3_ns_after_walk", K_GREEN, 0, -1, 20);

    // 4: conflicting emergency with tick low, then own-direction hold
    run_until("t4_reach_ew", K_GREEN, 1, 3, 200);
    bus.tick = 1'b0; bus.emg_req = 2'b01;
    step();
    chk("t4_yellow_now", 8'(bus.phase), 8'(EW_YELLOW));
    bus.tick = 1'b1;
    repeat (6) step();
    chk("t4_ns_green", 8'(bus.phase), 8'(NS_GREEN));
    chk("t4_preempt", 8'(bus.preempt_active), 8'd1);
    repeat (50) step();
    chk("t4_held", 8'(bus.ns_light), 8'b11);
    bus.emg_req = 2'b00;
    run_until("t4_resume_maxout", K_YELLOW, 0, -1, 45);

    // 5: simultaneous emergency, then walk aborted by EW emergency
    run_until("t5_reach_clear", K_CLEAR, -1, -1, 50);
    bus.emg_req = 2'b11;
    run_until("t5_ns_served", K_GREEN, 0, -1, 5);
    chk("t5_ew_red", 8'(bus.ew_light), 8'b00);
    bus.emg_req = 2'b00;
    pulse_ped();
    run_until("t5_reach_walk", K_WALK, -1, -1, 200);
    pulse_ped();
    bus.emg_req = 2'b10;
    step();
    chk("t5_abort", 8'(bus.phase), 8'(ALL_RED));
    run_until("t5_ew_served", K_GREEN, 1, -1, 5);
    bus.emg_req = 2'b00;

    // 6: async reset in NS yellow with a pending ped request
    run_until("t6_reach_ns", K_GREEN, 0, -1, 300);
    pulse_ped();
    run_until("t6_reach_yellow", K_YELLOW, 0, 1, 60);
    #1 rst = 1'b1;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    step(); step();
    chk("t6_restart_ns", 8'(bus.phase), 8'(NS_GREEN));

    // Randomized traffic against the model
    emg_hold = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      bus.tick    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.veh_req = 2'($urandom_range(0, 3));
      bus.ped_req = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 150) == 0)
        emg_hold = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      bus.emg_req = emg_hold;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
